// File: rtl/inv_atm_light_divider.sv
// Scaled inverse atmospheric light: Inv_c = floor(OMEGA_NUM / A_c) in Q0.14 for R, G, B,
// computed with one shared restoring divider, one quotient bit per cycle, R then G then B.
module inv_atm_light_divider #(
  parameter int OMEGA_NUM = 15360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A_R,
  input  logic [7:0]  A_G,
  input  logic [7:0]  A_B,
  output logic        busy,
  output logic        done,
  output logic [13:0] Inv_R,
  output logic [13:0] Inv_G,
  output logic [13:0] Inv_B
);

  localparam logic [13:0] OMEGA = 14'(OMEGA_NUM);
  localparam logic [3:0]  LAST_BIT_IDX = 4'd13;

  typedef enum logic {IDLE, DIV} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_r, a_g, a_b;
  logic [1:0]  ch;
  logic [3:0]  bit_cnt;
  logic [7:0]  rem;
  logic [13:0] dvd, quot;
  logic [13:0] hold_r, hold_g;

  logic [7:0]  divisor;
  logic [8:0]  trial;
  logic [7:0]  diff;
  logic        fits;
  logic [13:0] q_next, q_final;
  logic        last_bit, last_ch;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    divisor   = (ch == 2'd0) ? a_r : (ch == 2'd1) ? a_g : a_b;
    trial     = {rem, dvd[13]};
    fits      = trial >= {1'b0, divisor};
    // Remainder stays below the divisor, so the low byte of the difference is exact.
    diff      = trial[7:0] - divisor;
    q_next    = {quot[12:0], fits};
    q_final   = (divisor == 8'd0) ? 14'h3FFF : q_next;
    last_bit  = (bit_cnt == 4'd0);
    last_ch   = (ch == 2'd2);
    case (state)
      IDLE: if (start) state_nxt = DIV;
      DIV:  if (last_bit && last_ch) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; a_g <= '0; a_b <= '0;
      ch <= '0; bit_cnt <= '0; rem <= '0; dvd <= '0; quot <= '0;
      hold_r <= '0; hold_g <= '0;
      Inv_R <= '0; Inv_G <= '0; Inv_B <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r <= A_R; a_g <= A_G; a_b <= A_B;
          ch <= 2'd0; bit_cnt <= LAST_BIT_IDX;
          rem <= '0; dvd <= OMEGA; quot <= '0;
        end
        DIV: begin
          if (last_bit) begin
            // Channel finished: bank the quotient and reload for the next one, no bubble.
            bit_cnt <= LAST_BIT_IDX;
            rem <= '0; dvd <= OMEGA; quot <= '0;
            ch <= ch + 2'd1;
            case (ch)
              2'd0: hold_r <= q_final;
              2'd1: hold_g <= q_final;
              default: begin
                Inv_R <= hold_r;
                Inv_G <= hold_g;
                Inv_B <= q_final;
                done  <= 1'b1;
                ch    <= 2'd0;
              end
            endcase
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
            rem     <= fits ? diff : trial[7:0];
            dvd     <= {dvd[12:0], 1'b0};
            quot    <= q_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
